// File: rtl/audio_pkg.sv
// Shared fixed-point sample format and I2S receiver state encoding for the audio front end.
package audio_pkg;

    localparam int FXP_SIZE = 16;
    localparam int FXP_FRAC = 12;

    typedef logic signed [FXP_SIZE-1:0] sample_t;

    typedef enum logic [1:0] {
        SYNC,
        SHIFT,
        EMIT,
        DONE
    } i2s_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous line, plus a registered rising-edge pulse
// that is time-aligned with the delayed level output.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic level_q, level_d;
    logic rise_q, rise_d;

    always_comb begin
        meta_d  = i_async;
        sync_d  = meta_q;
        level_d = sync_q;
        rise_d  = sync_q & ~level_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    // o_rise is high in the same cycle that o_level shows the post-edge value.
    assign o_level = level_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/i2s_rx_frontend.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA in the clk domain, captures one channel's word
// and emits it as a signed Q4.12 sample with a one-cycle valid strobe.
module i2s_rx_frontend
    import audio_pkg::*;
#(
    parameter int WORD_BITS = 24,
    parameter int CHANNEL   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_bclk,
    input  logic                i_lrclk,
    input  logic                i_sdata,
    output logic                o_valid,
    output logic [FXP_SIZE-1:0] o_sample,
    output logic                o_frame_err
);

    localparam int                 CNT_W    = $clog2(WORD_BITS + 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(WORD_BITS);
    localparam int                 KEEP     = FXP_FRAC + 1;
    localparam logic               CH_LR    = (CHANNEL != 0);

    logic bclk_rise, bclk_level_unused;
    logic lr, lr_rise_unused;
    logic sd, sd_rise_unused;

    sync_edge_detect u_bclk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_bclk),
        .o_level (bclk_level_unused),
        .o_rise  (bclk_rise)
    );

    sync_edge_detect u_lrclk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_lrclk),
        .o_level (lr),
        .o_rise  (lr_rise_unused)
    );

    sync_edge_detect u_sdata_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_sdata),
        .o_level (sd),
        .o_rise  (sd_rise_unused)
    );

    i2s_state_t           state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d, cnt_next;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic                 lr_prev_q, lr_prev_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    sample_t              sample_q, sample_d;

    // NOTE: every _d gets its default first, so no branch can leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        lr_prev_d = lr_prev_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        sample_d  = sample_q;
        cnt_next  = bit_cnt_q + CNT_W'(1);

        if (bclk_rise) begin
            lr_prev_d = lr;
        end

        unique case (state_q)
            SYNC: begin
                // The rise where LRCLK turns to our channel still carries the other channel's LSB.
                if (bclk_rise && (lr != lr_prev_q) && (lr == CH_LR)) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (bclk_rise) begin
                    if ((lr != CH_LR) && (cnt_next != CNT_FULL)) begin
                        err_d   = 1'b1;
                        state_d = SYNC;
                    end else begin
                        word_d    = {word_q[WORD_BITS-2:0], sd};
                        bit_cnt_d = cnt_next;
                        if (cnt_next == CNT_FULL) begin
                            state_d  = EMIT;
                            valid_d  = 1'b1;
                            // Keep sign + 12 fraction bits, truncating the rest (floor).
                            sample_d = sample_t'({{(FXP_SIZE-KEEP){word_d[WORD_BITS-1]}},
                                                  word_d[WORD_BITS-1 -: KEEP]});
                        end
                    end
                end
            end
            EMIT: begin
                state_d = DONE;
            end
            DONE: begin
                if (bclk_rise && (lr != CH_LR)) begin
                    state_d = SYNC;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    // NOTE: the word shift register is reset along with the control state so no X ever reaches o_sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SYNC;
            bit_cnt_q <= '0;
            word_q    <= '0;
            lr_prev_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            sample_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            lr_prev_q <= lr_prev_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            sample_q  <= sample_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_sample    = sample_q;

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Self-checking bench: one I2S stream feeds a left-channel and a right-channel receiver;
// expected events come from a table of hand-computed frames and from a floor-division model.
module tb_i2s_rx_frontend;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_bclk, i_lrclk, i_sdata;
    logic        o_valid     [2];
    logic [15:0] o_sample    [2];
    logic        o_frame_err [2];

    always #5 clk = ~clk;

    i2s_rx_frontend #(.WORD_BITS(24), .CHANNEL(0)) dut_l (
        .clk         (clk),
        .rst         (rst),
        .i_bclk      (i_bclk),
        .i_lrclk     (i_lrclk),
        .i_sdata     (i_sdata),
        .o_valid     (o_valid[0]),
        .o_sample    (o_sample[0]),
        .o_frame_err (o_frame_err[0])
    );

    i2s_rx_frontend #(.WORD_BITS(24), .CHANNEL(1)) dut_r (
        .clk         (clk),
        .rst         (rst),
        .i_bclk      (i_bclk),
        .i_lrclk     (i_lrclk),
        .i_sdata     (i_sdata),
        .o_valid     (o_valid[1]),
        .o_sample    (o_sample[1]),
        .o_frame_err (o_frame_err[1])
    );

    typedef struct {
        bit          chan;
        bit          data;
        bit          has_ev;
        bit          is_err;
        logic [15:0] sample;
    } tbit_t;

    typedef struct {
        bit          chan;
        bit          is_err;
        logic [15:0] sample;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [23:0] lw;
        int          llen;
        logic [23:0] rw;
        int          rlen;
        bit          l_err;
        logic [15:0] l_samp;
        bit          r_err;
        logic [15:0] r_samp;
    } vec_t;

    tbit_t       stream [$];
    ev_t         exp_q  [$];
    ev_t         got_q  [$];
    vec_t        vecs   [7];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          mon_en = 0;
    logic        rst_seen;
    logic [15:0] held       [2];
    logic        prev_valid [2];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Signed 24-bit fraction scaled to Q4.12 with round toward minus infinity.
    function automatic logic [15:0] model_q412(input logic [23:0] w);
        int s;
        int q;
        s = int'(w);
        if (s >= 8388608) s = s - 16777216;
        q = (s >= 0) ? s / 2048 : -((-s + 2047) / 2048);
        return q[15:0];
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < 2; c++) begin
                if (rst_seen) held[c] = 16'h0000;
                if (o_valid[c]) begin
                    check("valid_back_to_back", prev_valid[c], 1'b0);
                    check("valid_with_err", o_frame_err[c], 1'b0);
                    got_q.push_back('{c[0], 1'b0, o_sample[c], cyc});
                    held[c] = o_sample[c];
                end else begin
                    check("sample_hold", o_sample[c], held[c]);
                end
                if (o_frame_err[c]) got_q.push_back('{c[0], 1'b1, 16'h0000, cyc});
                prev_valid[c] = o_valid[c];
            end
        end
    end

    // Queue one channel word; the event lands on bit min(len,24)-1.
    task automatic push_word(input bit chan, input logic [23:0] w, input int len,
                             input bit ev, input bit is_err, input logic [15:0] samp);
        tbit_t b;
        int    last;
        last = (len < 24) ? len - 1 : 23;
        for (int i = 0; i < len; i++) begin
            b.chan   = chan;
            b.data   = (i < 24) ? w[23-i] : 1'($urandom_range(0, 1));
            b.has_ev = ev && (i == last);
            b.is_err = is_err;
            b.sample = samp;
            stream.push_back(b);
        end
    endtask

    // LRCLK of each bit is the channel of the following bit (standard I2S one-bit lead).
    task automatic send_one();
        tbit_t b;
        b       = stream.pop_front();
        i_bclk  = 1'b0;
        i_lrclk = stream[0].chan;
        i_sdata = b.data;
        repeat (4) @(negedge clk);
        i_bclk = 1'b1;
        if (b.has_ev) exp_q.push_back('{b.chan, b.is_err, b.sample, cyc + 4});
        repeat (4) @(negedge clk);
    endtask

    task automatic transmit_all();
        while (stream.size() > 1) send_one();
    endtask

    task automatic drain();
        ev_t e;
        ev_t g;
        repeat (6) @(negedge clk);
        check("event_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check("event_channel", g.chan, e.chan);
            check("event_is_err", g.is_err, e.is_err);
            check("event_cycle", g.cyc, e.cyc);
            if (!e.is_err) check("event_sample", g.sample, e.sample);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_outputs_zero();
        for (int c = 0; c < 2; c++) begin
            check("reset_valid", o_valid[c], 1'b0);
            check("reset_frame_err", o_frame_err[c], 1'b0);
            check("reset_sample", o_sample[c], 16'h0000);
        end
    endtask

    initial begin
        vecs[0] = '{24'h400000, 24, 24'h123456, 24, 1'b0, 16'h0800, 1'b0, 16'h0246};
        vecs[1] = '{24'h7FFFFF, 24, 24'hC00000, 24, 1'b0, 16'h0FFF, 1'b0, 16'hF800};
        vecs[2] = '{24'h800000, 24, 24'h000000, 24, 1'b0, 16'hF000, 1'b0, 16'h0000};
        vecs[3] = '{24'hFFFFFF, 24, 24'h200000, 24, 1'b0, 16'hFFFF, 1'b0, 16'h0400};
        vecs[4] = '{24'hABCDEF, 11, 24'h7FFFFF, 24, 1'b1, 16'h0000, 1'b0, 16'h0FFF};
        vecs[5] = '{24'h200000, 24, 24'h800000, 24, 1'b0, 16'h0400, 1'b0, 16'hF000};
        vecs[6] = '{24'h400000, 32, 24'hFFFFFF, 32, 1'b0, 16'h0800, 1'b0, 16'hFFFF};
        held[0] = 16'h0000;
        held[1] = 16'h0000;
        prev_valid[0] = 1'b0;
        prev_valid[1] = 1'b0;

        rst     = 1'b1;
        i_bclk  = 1'b0;
        i_lrclk = 1'b0;
        i_sdata = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Preamble: one left bit then one right bit so both receivers see an LRCLK transition.
        // The lone right bit is a one-bit word, so the right receiver flags it as short.
        push_word(1'b0, 24'h000000, 1, 1'b0, 1'b0, 16'h0000);
        push_word(1'b1, 24'h000000, 1, 1'b1, 1'b1, 16'h0000);

        for (int i = 0; i < 7; i++) begin
            push_word(1'b0, vecs[i].lw, vecs[i].llen, 1'b1, vecs[i].l_err, vecs[i].l_samp);
            push_word(1'b1, vecs[i].rw, vecs[i].rlen, 1'b1, vecs[i].r_err, vecs[i].r_samp);
            transmit_all();
            drain();
        end

        // Reset eight bits into a left word: that word is lost silently, the right word survives.
        push_word(1'b0, 24'h123456, 24, 1'b0, 1'b0, 16'h0000);
        push_word(1'b1, 24'h400000, 24, 1'b1, 1'b0, 16'h0800);
        for (int i = 0; i < 9; i++) send_one();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outputs_zero();
        push_word(1'b0, 24'h200000, 24, 1'b1, 1'b0, 16'h0400);
        push_word(1'b1, 24'hC00000, 24, 1'b1, 1'b0, 16'hF800);
        transmit_all();
        drain();

        // Random frames: mostly 24-bit words, some 32-bit slots, some short words.
        for (int f = 0; f < 16; f++) begin
            for (int ch = 0; ch < 2; ch++) begin
                int          pick;
                int          len;
                logic [23:0] w;
                pick = int'($urandom_range(0, 9));
                len  = (pick == 0) ? int'($urandom_range(4, 20)) : (pick == 1) ? 32 : 24;
                w    = 24'($urandom);
                push_word(ch[0], w, len, 1'b1, len < 24, model_q412(w));
            end
            transmit_all();
            drain();
        end

        push_word(1'b0, 24'h000000, 1, 1'b0, 1'b0, 16'h0000);
        transmit_all();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
